// File: rtl/clock_timekeeper_pkg.sv
// Shared definitions for the clock timekeeper: FSM state encoding, BCD
// limit constants and the 24 h -> 12 h display conversion helper.
package clock_timekeeper_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_t;

   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;

   // Converts an internal BCD hour 00..23 into {pm, 12 h BCD hour 01..12}.
   function automatic logic [8:0] hour_to_12h(input logic [7:0] hour_bcd);
      logic [4:0] bin;
      logic [4:0] h12;
      logic [4:0] ones5;
      logic       pm;
      bin = ({1'b0, hour_bcd[7:4]} * 5'd10) + {1'b0, hour_bcd[3:0]};
      pm  = (bin >= 5'd12);
      if (bin == 5'd0) begin
         h12 = 5'd12;
      end else if (bin > 5'd12) begin
         h12 = bin - 5'd12;
      end else begin
         h12 = bin;
      end
      if (h12 >= 5'd10) begin
         ones5 = h12 - 5'd10;
         return {pm, 4'h1, ones5[3:0]};
      end else begin
         return {pm, 4'h0, h12[3:0]};
      end
   endfunction

endpackage

// File: rtl/clock_timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MAX to 00. Clear has priority over
// increment; carry flags the increment that performs the wrap.
module bcd_mod_counter
   import clock_timekeeper_pkg::*;
#(
   parameter logic [7:0] MAX = SEC_MAX
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry
);

   logic [7:0] value_r;
   logic [7:0] value_next_s;
   logic       at_max_s;

   assign at_max_s = (value_r == MAX);
   assign carry    = inc && !clr && at_max_s;
   assign tens     = value_r[7:4];
   assign ones     = value_r[3:0];

   // Next BCD value: clear, wrap at MAX, decimal carry from ones to tens.
   always_comb begin
      value_next_s = value_r;
      if (clr) begin
         value_next_s = 8'h00;
      end else if (inc) begin
         if (at_max_s) begin
            value_next_s = 8'h00;
         end else if (value_r[3:0] == 4'd9) begin
            value_next_s = {value_r[7:4] + 4'd1, 4'd0};
         end else begin
            value_next_s = {value_r[7:4], value_r[3:0] + 4'd1};
         end
      end else begin
         value_next_s = value_r;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value_r <= 8'h00;
      end else begin
         value_r <= value_next_s;
      end
   end

endmodule

// File: rtl/clock_timekeeper.sv
// Real-time clock core: prescaler, hh:mm:ss BCD counters, RUN/SET FSM and a
// registered packed display word. Optional build macro CLOCK_HOUR12_EN
// selects a 12 h displayed hour with a PM flag in data[27].
module clock_timekeeper #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mode_pulse,
   input  logic        inc_pulse,
   output logic [31:0] data,
   output logic        sec_tick,
   output logic [1:0]  mode
);
   import clock_timekeeper_pkg::*;

   localparam int              PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);

   state_t          state_r;
   state_t          next_state_s;
   logic [PW-1:0]   prescaler_r;
   logic            tick_s;
   logic            enter_set_s;
   logic            set_inc_s;
   logic            min_inc_s;
   logic            hour_inc_s;
   logic            sec_carry_s;
   logic            min_carry_s;
   logic            hour_carry_s;
   logic [3:0]      sec_t_s, sec_o_s, min_t_s, min_o_s, hour_t_s, hour_o_s;
   logic [7:0]      disp_hour_s;
   logic            pm_s;
   logic [31:0]     data_r;
   logic            sec_tick_r;

   // A second only elapses in RUN; a simultaneous mode_pulse leaves RUN instead.
   assign tick_s      = (state_r == ST_RUN) && !mode_pulse && (prescaler_r == PRE_MAX);
   assign enter_set_s = (state_r == ST_RUN) && mode_pulse;
   assign set_inc_s   = inc_pulse && !mode_pulse;
   assign min_inc_s   = sec_carry_s || ((state_r == ST_SET_MIN) && set_inc_s);
   assign hour_inc_s  = (sec_carry_s && min_carry_s) || ((state_r == ST_SET_HOUR) && set_inc_s);

   // Mode FSM next state: mode_pulse cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_RUN:      if (mode_pulse) next_state_s = ST_SET_HOUR; else next_state_s = ST_RUN;
         ST_SET_HOUR: if (mode_pulse) next_state_s = ST_SET_MIN;  else next_state_s = ST_SET_HOUR;
         ST_SET_MIN:  if (mode_pulse) next_state_s = ST_RUN;      else next_state_s = ST_SET_MIN;
         default:     next_state_s = ST_RUN;
      endcase
   end

   // Mode FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Prescaler: held at 0 outside RUN (also on the edge back into RUN).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prescaler_r <= '0;
      end else if ((state_r != ST_RUN) || mode_pulse || tick_s) begin
         prescaler_r <= '0;
      end else begin
         prescaler_r <= prescaler_r + 1'b1;
      end
   end

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk(clk), .resetn(resetn), .clr(enter_set_s), .inc(tick_s),
      .tens(sec_t_s), .ones(sec_o_s), .carry(sec_carry_s)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk(clk), .resetn(resetn), .clr(1'b0), .inc(min_inc_s),
      .tens(min_t_s), .ones(min_o_s), .carry(min_carry_s)
   );

   bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk(clk), .resetn(resetn), .clr(1'b0), .inc(hour_inc_s),
      .tens(hour_t_s), .ones(hour_o_s), .carry(hour_carry_s)
   );

   // Displayed hour: internal 24 h value, or 12 h value plus PM flag.
   always_comb begin
      disp_hour_s = {hour_t_s, hour_o_s};
      pm_s        = 1'b0;
`ifdef CLOCK_HOUR12_EN
      {pm_s, disp_hour_s} = hour_to_12h({hour_t_s, hour_o_s});
`else
      disp_hour_s = {hour_t_s, hour_o_s};
      pm_s        = 1'b0;
`endif
   end

   // Registered outputs: display word and second tick, one cycle behind state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_r     <= 32'h0000_0000;
         sec_tick_r <= 1'b0;
      end else begin
         data_r     <= {4'h0, pm_s, 1'b0, state_r, disp_hour_s,
                        min_t_s, min_o_s, sec_t_s, sec_o_s};
         sec_tick_r <= tick_s;
      end
   end

   assign data     = data_r;
   assign sec_tick = sec_tick_r;
   assign mode     = state_r;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper with CLK_HZ = 10. Expected display
// words come from an integer time model and go through a scoreboard queue.
module tb_clock_timekeeper;

   localparam int CLK_HZ = 10;

   logic        clk;
   logic        resetn;
   logic        mode_pulse;
   logic        inc_pulse;
   logic [31:0] data;
   logic        sec_tick;
   logic [1:0]  mode;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_w;

   int m_mode, m_h, m_m, m_s;

   clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
      .clk(clk), .resetn(resetn), .mode_pulse(mode_pulse),
      .inc_pulse(inc_pulse), .data(data), .sec_tick(sec_tick), .mode(mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   function automatic logic [31:0] exp_word(input int md, input int h, input int m, input int s);
      int         hh;
      logic       pm;
      logic [1:0] mdv;
      hh  = h;
      pm  = 1'b0;
`ifdef CLOCK_HOUR12_EN
      pm = (h >= 12);
      hh = h % 12;
      if (hh == 0) hh = 12;
`endif
      mdv = 2'(md);
      return {4'h0, pm, 1'b0, mdv, 4'(hh / 10), 4'(hh % 10),
              4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic m, input logic i);
      mode_pulse = m;
      inc_pulse  = i;
      step();
      mode_pulse = 1'b0;
      inc_pulse  = 1'b0;
   endtask

   // Steps until sec_tick is seen; cycles = -1 if the bound expires.
   task automatic wait_tick(output int cycles);
      cycles = -1;
      for (int n = 1; n <= 4 * CLK_HZ; n++) begin
         step();
         if (sec_tick === 1'b1) begin
            cycles = n;
            break;
         end
      end
   endtask

   task automatic push_model();
      exp_q.push_back(exp_word(m_mode, m_h, m_m, m_s));
   endtask

   task automatic test_reset();
      resetn = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      repeat (3) step();
      exp_q.push_back(32'h0000_0000);
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL reset_data: got %h, required %h", data, exp_w);
      else n_pass++;
      n_checks++;
      if (mode !== 2'd0) $display("FAIL reset_mode: got %0d, required 0", mode);
      else n_pass++;
      n_checks++;
      if (sec_tick !== 1'b0) $display("FAIL reset_tick: got %b, required 0", sec_tick);
      else n_pass++;
   endtask

   task automatic test_run();
      int cyc;
      resetn = 1'b1;
      wait_tick(cyc);
      n_checks++;
      if (cyc !== CLK_HZ) $display("FAIL run_first_tick: got %0d cycles, required %0d", cyc, CLK_HZ);
      else n_pass++;
      m_s = 1;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w || data !== 32'h0000_0001) $display("FAIL run_data: got %h, required %h", data, exp_w);
      else n_pass++;
      n_checks++;
      if (sec_tick !== 1'b0) $display("FAIL run_tick_width: got %b, required 0", sec_tick);
      else n_pass++;
   endtask

   task automatic test_set();
      int cyc;
      pulse(1'b1, 1'b0);
      m_mode = 1; m_s = 0;
      for (int i = 0; i < 3; i++) begin
         pulse(1'b0, 1'b1);
         m_h = (m_h + 1) % 24;
      end
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL set_hour_data: got %h, required %h", data, exp_w);
      else n_pass++;
      pulse(1'b1, 1'b0);
      m_mode = 2;
      for (int i = 0; i < 61; i++) begin
         pulse(1'b0, 1'b1);
         m_m = (m_m + 1) % 60;
      end
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL set_min_data: got %h, required %h", data, exp_w);
      else n_pass++;
      pulse(1'b1, 1'b0);
      m_mode = 0;
      wait_tick(cyc);
      n_checks++;
      if (cyc !== CLK_HZ) $display("FAIL set_return_tick: got %0d cycles, required %0d", cyc, CLK_HZ);
      else n_pass++;
      m_s = 1;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL set_run_data: got %h, required %h", data, exp_w);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      pulse(1'b1, 1'b0);
      m_mode = 1; m_s = 0;
      pulse(1'b1, 1'b1);
      m_mode = 2;
      n_checks++;
      if (mode !== 2'd2) $display("FAIL simul_mode: got %0d, required 2", mode);
      else n_pass++;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL simul_data: got %h, required %h", data, exp_w);
      else n_pass++;
   endtask

   task automatic test_reset_mid_set();
      resetn = 1'b0;
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL midreset_data: got %h, required %h", data, exp_w);
      else n_pass++;
      n_checks++;
      if (mode !== 2'd0) $display("FAIL midreset_mode: got %0d, required 0", mode);
      else n_pass++;
      step();
      resetn = 1'b1;
   endtask

   task automatic test_wrap();
      int cyc;
      int bad;
      pulse(1'b1, 1'b0);
      repeat (23) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      repeat (59) pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      m_mode = 0; m_h = 23; m_m = 59; m_s = 0;
      bad = 0;
      for (int i = 0; i < 59; i++) begin
         wait_tick(cyc);
         if (cyc != CLK_HZ) bad++;
         if (cyc < 0) break;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL wrap_tick_period: got %0d bad intervals, required 0", bad);
      else n_pass++;
      m_s = 59;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL wrap_pre_data: got %h, required %h", data, exp_w);
      else n_pass++;
      wait_tick(cyc);
      n_checks++;
      if (cyc !== CLK_HZ - 1) $display("FAIL wrap_tick: got %0d cycles, required %0d", cyc, CLK_HZ - 1);
      else n_pass++;
      m_h = 0; m_m = 0; m_s = 0;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL wrap_data: got %h, required %h", data, exp_w);
      else n_pass++;
   endtask

   task automatic test_hour13();
      logic pm_exp;
      pulse(1'b1, 1'b0);
      repeat (13) pulse(1'b0, 1'b1);
      m_mode = 1; m_h = 13; m_m = 0; m_s = 0;
      push_model();
      step();
      exp_w = exp_q.pop_front();
      n_checks++;
      if (data !== exp_w) $display("FAIL hour13_data: got %h, required %h", data, exp_w);
      else n_pass++;
`ifdef CLOCK_HOUR12_EN
      pm_exp = 1'b1;
`else
      pm_exp = 1'b0;
`endif
      n_checks++;
      if (data[27] !== pm_exp) $display("FAIL hour13_pm: got %b, required %b", data[27], pm_exp);
      else n_pass++;
   endtask

   initial begin
      resetn = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
      test_reset();
      test_run();
      test_set();
      test_simultaneous();
      test_reset_mid_set();
      test_wrap();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      test_hour13();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/clock_timekeeper.md
CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clk cycles per second.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port mode_pulse, input, 1: one-cycle synchronous pulse, already debounced; advances the set mode.
REQ-005 SHALL have port inc_pulse, input, 1: one-cycle synchronous pulse, already debounced; increments the selected field.
REQ-006 SHALL have port data, output, 32: packed BCD display word for the 8-digit seven-segment driver; registered.
REQ-007 SHALL have port sec_tick, output, 1: one-cycle pulse when seconds advance.
REQ-008 SHALL have port mode, output, 2: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.

Function
REQ-009 SHALL hold a prescaler counting 0..CLK_HZ-1; the terminal count produces sec_tick for one cycle and wraps the prescaler to 0.
REQ-010 SHALL keep sec, min and hour as BCD digit pairs: sec 00..59, min 00..59, hour 00..23 (internal 24 h).
REQ-011 SHALL, in RUN on sec_tick, increment sec; 59 wraps to 00 with min carry; min 59 wraps to 00 with hour carry; hour 23 wraps to 00.
REQ-012 SHALL use a 3-state FSM: RUN -mode_pulse-> SET_HOUR -mode_pulse-> SET_MIN -mode_pulse-> RUN.
REQ-013 SHALL, on entry to SET_HOUR, clear sec to 00 and the prescaler to 0; both stay 0 and sec_tick stays 0 in SET_HOUR and SET_MIN.
REQ-014 SHALL, on inc_pulse, increment hour (mod 24) in SET_HOUR and min (mod 60, no hour carry) in SET_MIN; inc_pulse is ignored in RUN.
REQ-015 SHALL give mode_pulse priority when mode_pulse and inc_pulse arrive together: the state advances and the increment is dropped.
REQ-016 SHALL restart the prescaler from 0 on return to RUN, so the first sec_tick comes exactly CLK_HZ cycles after the transition.
REQ-017 SHALL pack data as {4'h0, 2'b0, mode, hour_t, hour_o, min_t, min_o, sec_t, sec_o}, with bits [31:24] the mode indicator.
REQ-018 SHALL update data one cycle after the counter or state change (registered output, latency 1).

Reset
REQ-019 SHALL, while resetn = 0, hold state RUN, prescaler 0, time 00:00:00, data 32'h0000_0000, sec_tick 0 and mode 0.
REQ-020 SHALL, on reset mid-operation (including in SET states), abort at once to the REQ-019 values; the first sec_tick comes CLK_HZ cycles after release.

Configuration
REQ-021 SHALL support macro CLOCK_HOUR12_EN.
- Defined: the displayed hour is 12-h BCD (internal 00 -> 12, 13..23 -> 01..11, 12 -> 12) and data[27] = 1 for internal hours 12..23 (PM).
- Undefined: the displayed hour is the internal 00..23 and data[27] = 0.
- Internal counting and set behaviour are identical in both builds.

Structure
REQ-022 SHALL place the state encoding (RUN/SET_HOUR/SET_MIN) and the BCD limit constants (59, 23) in the shared clock package.
REQ-023 SHALL use one sub-module, bcd_mod_counter: a 2-digit BCD counter with parameterised max, inc enable, clear, carry out; instantiated for sec, min and hour.

Verification
REQ-024 SHALL cover these scenarios, with CLK_HZ = 10:
- Run from reset: 10 cycles -> sec_tick once, data = 32'h0000_0001.
- Wrap: preload 23:59:59, one sec_tick -> data = 32'h0000_0000; with CLOCK_HOUR12_EN -> hour shows 12, PM bit 0.
- Set: mode_pulse, inc_pulse x3 -> data = 32'h0103_xx00; mode_pulse, inc_pulse x61 -> min 01, hour unchanged; mode_pulse -> RUN, sec_tick exactly 10 cycles later.
- Simultaneous: mode_pulse and inc_pulse in the same cycle in SET_HOUR -> state SET_MIN, hour unchanged.
- Reset mid-set: resetn low in SET_MIN -> next cycle data = 0, mode = 0.
- 12-h build: internal hour 13 -> hour digits 01, data[27] = 1.
